text_buffer: RTL

Parametrised character-cell text buffer. It takes ASCII codes from the keyboard path (valid/ready), keeps a COLS×ROWS screen memory with cursor, newline, backspace and overflow handling (hardware scroll or wrap), and serves a registered read port to the VGA/font path by logical (x, y) cell. It sits between the PS/2 decoder and the VGA character renderer. It replaces the fixed-size, write-only-append screen memory with a configurable one that scrolls.

---
 rtl/text_buffer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/text_buffer.sv
// text_buffer: COLS x ROWS character screen fed by the keyboard path,
// with cursor, newline, backspace, scroll or wrap, and a registered read port.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   in_valid/in_ascii    incoming ASCII code; in_ready high only when idle
//   clear                pulse: blank the whole screen, home the cursor
//   rd_x/rd_y, rd_char   logical cell read, one cycle latency
//   cur_x/cur_y          cursor position (logical)
module text_buffer #(
  parameter int COLS      = 70,
  parameter int ROWS      = 30,
  parameter int CW        = 7,
  parameter int RW        = 5,
  parameter bit SCROLL_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_ascii,
  output logic          in_ready,
  input  logic          clear,
  input  logic [CW-1:0] rd_x,
  input  logic [RW-1:0] rd_y,
  output logic [7:0]    rd_char,
  output logic [CW-1:0] cur_x,
  output logic [RW-1:0] cur_y
);

  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);
  localparam int CW1   = CW + 1;
  localparam int RW1   = RW + 1;

  localparam logic [1:0] S_FULL = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_ROW  = 2'd2;

  localparam logic [CW-1:0] LAST_X    = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_Y    = RW'(ROWS - 1);
  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
  localparam logic [7:0]    BLANK     = 8'h20;

  logic [1:0]    state;
  logic [AW-1:0] clr_cnt;
  logic [RW-1:0] clr_row;
  logic [CW-1:0] clr_col;
  logic [RW-1:0] top_row;
  logic [7:0]    mem [CELLS];

  // Logical row to physical row; ROWS need not be a power of two.
  function automatic logic [RW-1:0] phys_row(
    input logic [RW-1:0] ly,
    input logic [RW-1:0] top
  );
    logic [RW:0] s;
    s = {1'b0, ly} + {1'b0, top};
    if (s >= RW1'(ROWS)) s = s - RW1'(ROWS);
    return s[RW-1:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(
    input logic [RW-1:0] prow,
    input logic [CW-1:0] col
  );
    return AW'(prow) * AW'(COLS) + AW'(col);
  endfunction

  logic          hs;
  logic          is_print;
  logic          is_nl;
  logic          is_bs;
  logic          at_eol;
  logic          adv;
  logic [RW-1:0] cur_prow;
  logic [RW-1:0] up_prow;

  assign in_ready = (state == S_IDLE);
  // A clear in the same cycle swallows the handshake.
  assign hs       = in_valid & in_ready & ~clear;
  assign is_print = (in_ascii >= 8'h20) && (in_ascii <= 8'h7E);
  assign is_nl    = (in_ascii == 8'h0A) || (in_ascii == 8'h0D);
  assign is_bs    = (in_ascii == 8'h08);
  assign at_eol   = (cur_x == LAST_X);
  assign adv      = hs & (is_nl | (is_print & at_eol));
  assign cur_prow = phys_row(cur_y, top_row);
  assign up_prow  = phys_row(cur_y - 1'b1, top_row);

  logic          we;
  logic [AW-1:0] wa;
  logic [7:0]    wd;

  always_comb begin
    we = 1'b0;
    wa = '0;
    wd = BLANK;
    if (!reset && !clear) begin
      unique case (1'b1)
        state == S_FULL: begin
          we = 1'b1;
          wa = clr_cnt;
        end
        state == S_ROW: begin
          we = 1'b1;
          wa = cell_addr(clr_row, clr_col);
        end
        hs && is_print: begin
          we = 1'b1;
          wa = cell_addr(cur_prow, cur_x);
          wd = in_ascii;
        end
        hs && is_bs: begin
          if (cur_x != '0) begin
            we = 1'b1;
            wa = cell_addr(cur_prow, cur_x - 1'b1);
          end else if (cur_y != '0) begin
            we = 1'b1;
            wa = cell_addr(up_prow, LAST_X);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state   <= S_FULL;
      clr_cnt <= '0;
      clr_row <= '0;
      clr_col <= '0;
      top_row <= '0;
      cur_x   <= '0;
      cur_y   <= '0;
    end else begin
      unique case (1'b1)
        state == S_FULL: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_CELL) state <= S_IDLE;
        end
        state == S_ROW: begin
          clr_col <= clr_col + 1'b1;
          if (clr_col == LAST_X) state <= S_IDLE;
        end
        hs: begin
          if (is_print) begin
            cur_x <= at_eol ? '0 : cur_x + 1'b1;
          end else if (is_nl) begin
            cur_x <= '0;
          end else if (is_bs) begin
            if (cur_x != '0) begin
              cur_x <= cur_x - 1'b1;
            end else if (cur_y != '0) begin
              cur_x <= LAST_X;
              cur_y <= cur_y - 1'b1;
            end
          end
          if (adv) begin
            clr_col <= '0;
            if (cur_y != LAST_Y) begin
              cur_y <= cur_y + 1'b1;
            end else begin
              // Old top row becomes the new bottom (scroll) or
              // is logical row 0 (wrap); either way it gets blanked.
              state   <= S_ROW;
              clr_row <= top_row;
              if (SCROLL_EN) begin
                top_row <= (top_row == LAST_Y) ? '0 : top_row + 1'b1;
              end else begin
                cur_y <= '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  logic          rd_oob;
  logic [AW-1:0] rd_addr;

  assign rd_oob  = ({1'b0, rd_x} >= CW1'(COLS)) ||
                   ({1'b0, rd_y} >= RW1'(ROWS));
  assign rd_addr = cell_addr(phys_row(rd_y, top_row), rd_x);

  always_ff @(posedge clk) begin
    if (reset) rd_char <= BLANK;
    else       rd_char <= rd_oob ? BLANK : mem[rd_addr];
  end

endmodule
